control: RTL and testbench
==========================

# control

Sequencing controller for the LC-3b multicycle datapath. It is a Moore state machine that steps each instruction through fetch, decode and execute. It drives every load enable, mux select, ALU operation and memory strobe in the datapath, from the opcode and mode bits the instruction register decodes. It sits beside the datapath in the CPU top level and is the only agent that issues memory requests.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  4 (lc3b_opcode)  decoded opcode from the instruction register
- instruction5  in  1  IR bit 5: 1 = imm5 form of ADD/AND
- branch_enable  in  1  nzp match from the CC compare logic
- mem_resp  in  1  memory has completed the current read or write this cycle
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc  out  1 each  register load enables
- pcmux_sel  out  2  0 = PC+2, 1 = branch adder (PC+sext(offset9)<<1), 2 = SR1 value
- marmux_sel  out  1  0 = ALU out, 1 = PC
- mdrmux_sel  out  1  0 = ALU out, 1 = mem_rdata
- alumux_sel  out  2  0 = SR2 value, 1 = sext(imm5), 2 = sext(offset6)<<1
- regfilemux_sel  out  2  0 = ALU out, 1 = MDR, 2 = branch adder
- storemux_sel  out  1  SR1 read address: 0 = IR[8:6], 1 = IR[11:9]
- aluop  out  lc3b_aluop  alu_add, alu_and, alu_not, alu_pass
- mem_read, mem_write  out  1 each  memory strobes

## Operation
- Outputs are decoded combinationally from the state only (Moore). Every output defaults to 0 and is raised only in the states listed below.
- While reset is high, all load enables and memory strobes are 0. The next state is FETCH1.
- FETCH1: marmux_sel=1, load_mar, pcmux_sel=0, load_pc. Next state FETCH2.
- FETCH2: mem_read, mdrmux_sel=1, load_mdr. Stay in FETCH2 until mem_resp=1, then go to FETCH3.
- FETCH3: load_ir. Next state DECODE.
- DECODE: no outputs.
  - op_add → ADD, op_and → AND, op_not → NOT, op_br → BR, op_jmp → JMP, op_lea → LEA.
  - op_ldr and op_str → CALC_ADDR.
  - Any other opcode → FETCH1, executed as a no-op.
- ADD / AND: aluop=alu_add / alu_and, alumux_sel=instruction5, regfilemux_sel=0, load_regfile, load_cc. Next state FETCH1.
- NOT: aluop=alu_not, load_regfile, load_cc. Next state FETCH1.
- LEA: regfilemux_sel=2, load_regfile, load_cc. Next state FETCH1.
- BR: no outputs. Next state BR_TAKEN if branch_enable=1, else FETCH1.
- BR_TAKEN: pcmux_sel=1, load_pc. Next state FETCH1.
- JMP: pcmux_sel=2, load_pc. Next state FETCH1.
- CALC_ADDR: alumux_sel=2, aluop=alu_add, marmux_sel=0, load_mar. Next state LDR1 for op_ldr, STR1 for op_str.
- LDR1: mem_read, mdrmux_sel=1, load_mdr. Stay until mem_resp=1, then go to LDR2.
- LDR2: regfilemux_sel=1, load_regfile, load_cc. Next state FETCH1.
- STR1: storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr. Next state STR2.
- STR2: mem_write. Stay until mem_resp=1, then go to FETCH1.
- opcode and instruction5 are sampled only in DECODE and the execute states. The IR is stable from FETCH3 until the next FETCH3.

## Timing
- Latency with memory responding in its first requested cycle (minimum 3 fetch cycles):
  - ADD/AND/NOT/LEA/JMP: 5 cycles.
  - BR not taken: 5 cycles; BR taken: 6 cycles.
  - LDR: 7 cycles; STR: 7 cycles.
  - Unknown opcode: 4 cycles.
- Each extra memory wait cycle adds exactly 1 cycle to the instruction.
- mem_read and mem_write are held continuously until the cycle in which mem_resp is sampled high. They drop the cycle after.
- mem_resp while no strobe is active is ignored.
- Reset mid-operation: reset is sampled on the edge and outranks everything.
  - Strobes are forced low while reset is asserted.
  - The state is FETCH1 the cycle after reset deasserts, even mid-FETCH2, LDR1 or STR2.
- First cycle after reset deasserts: load_mar=1, marmux_sel=1, load_pc=1, pcmux_sel=0, all other outputs 0.

## Test plan
- Reset then idle memory: after 2 reset cycles, FETCH1 outputs appear. mem_read is held for 4 cycles while mem_resp=0, then drops one cycle after mem_resp=1.
- ADD R1,R2,#5 (opcode op_add, instruction5=1), mem_resp in first cycle: in the 5th cycle, load_regfile=1, load_cc=1, alumux_sel=1, aluop=alu_add.
- STR with 3-cycle write latency: STR1 shows load_mdr=1, storemux_sel=1, aluop=alu_pass. mem_write is high for exactly 3 cycles. FETCH1 follows on the next cycle.
- BR with branch_enable=0, then branch_enable=1: the not-taken branch has no load_pc after FETCH1. The taken branch shows load_pc=1 with pcmux_sel=1 in cycle 6.
- Reset asserted in the 2nd cycle of FETCH2: mem_read is 0 in that same cycle. FETCH1 outputs appear on the cycle after deassertion.
- Unknown opcode (e.g. op_trap): DECODE returns to FETCH1 with no load_regfile, load_pc or mem strobe issued.

Source files
------------

// File: rtl/control.sv
// LC-3b multicycle sequencing controller: Moore FSM stepping each instruction
// through fetch, decode and execute, driving all datapath controls.
package lc3b_types;
  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;
endpackage

module control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  lc3b_opcode opcode,
  input  logic       instruction5,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic [1:0] pcmux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic [1:0] alumux_sel,
  output logic [1:0] regfilemux_sel,
  output logic       storemux_sel,
  output lc3b_aluop  aluop,
  output logic       mem_read,
  output logic       mem_write
);

  typedef enum logic [3:0] {
    s_fetch1, s_fetch2, s_fetch3, s_decode,
    s_add, s_and, s_not, s_lea, s_br, s_br_taken, s_jmp,
    s_calc_addr, s_ldr1, s_ldr2, s_str1, s_str2
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= s_fetch1;
    end else begin
      case (state)
        s_fetch1: state <= s_fetch2;
        s_fetch2: if (mem_resp) state <= s_fetch3;
        s_fetch3: state <= s_decode;
        s_decode: begin
          case (opcode)
            op_add:         state <= s_add;
            op_and:         state <= s_and;
            op_not:         state <= s_not;
            op_br:          state <= s_br;
            op_jmp:         state <= s_jmp;
            op_lea:         state <= s_lea;
            op_ldr, op_str: state <= s_calc_addr;
            default:        state <= s_fetch1;
          endcase
        end
        s_br:        state <= branch_enable ? s_br_taken : s_fetch1;
        s_calc_addr: state <= (opcode == op_ldr) ? s_ldr1 : s_str1;
        s_ldr1:      if (mem_resp) state <= s_ldr2;
        s_str1:      state <= s_str2;
        s_str2:      if (mem_resp) state <= s_fetch1;
        default:     state <= s_fetch1;
      endcase
    end
  end

  // Reset gates the state decode so strobes drop in the very cycle reset is high.
  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    pcmux_sel      = '0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    alumux_sel     = '0;
    regfilemux_sel = '0;
    storemux_sel   = 1'b0;
    aluop          = alu_add;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (!reset) begin
      case (state)
        s_fetch1: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
        end
        s_fetch2, s_ldr1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        s_fetch3: load_ir = 1'b1;
        s_add, s_and: begin
          aluop        = (state == s_add) ? alu_add : alu_and;
          alumux_sel   = {1'b0, instruction5};
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        s_not: begin
          aluop        = alu_not;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        s_lea: begin
          regfilemux_sel = 2'd2;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        s_br_taken: begin
          pcmux_sel = 2'd1;
          load_pc   = 1'b1;
        end
        s_jmp: begin
          pcmux_sel = 2'd2;
          load_pc   = 1'b1;
        end
        s_calc_addr: begin
          alumux_sel = 2'd2;
          aluop      = alu_add;
          load_mar   = 1'b1;
        end
        s_ldr2: begin
          regfilemux_sel = 2'd1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        s_str1: begin
          storemux_sel = 1'b1;
          aluop        = alu_pass;
          load_mdr     = 1'b1;
        end
        s_str2:  mem_write = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: per-instruction cycle plans from a reference
// model are queued by the driver and compared cycle by cycle by a monitor.
module tb_control;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  lc3b_opcode opcode = op_br;
  logic       instruction5 = 1'b0;
  logic       branch_enable = 1'b0;
  logic       mem_resp = 1'b0;
  logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic [1:0] pcmux_sel, alumux_sel, regfilemux_sel;
  logic       marmux_sel, mdrmux_sel, storemux_sel;
  lc3b_aluop  aluop;
  logic       mem_read, mem_write;

  control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .instruction5(instruction5),
    .branch_enable(branch_enable), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_cc(load_cc),
    .pcmux_sel(pcmux_sel), .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel),
    .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
    .storemux_sel(storemux_sel), .aluop(aluop),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic [1:0] pcmux;
    logic       marmux, mdrmux;
    logic [1:0] alumux, regfilemux;
    logic       storemux;
    lc3b_aluop  aluop;
    logic       mem_read, mem_write;
  } outv_t;

  typedef struct {
    string      tag;
    outv_t      exp;
    logic       resp, rst, i5, be;
    lc3b_opcode op;
  } cyc_t;

  cyc_t sb[$];
  cyc_t plan[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  function automatic logic rj();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic lc3b_opcode jop();
    return lc3b_opcode'($urandom_range(0, 15));
  endfunction

  function automatic void add(string tag, outv_t e, logic resp, lc3b_opcode op, logic i5, logic be);
    cyc_t c;
    c.tag = tag; c.exp = e; c.resp = resp; c.rst = 1'b0;
    c.op = op; c.i5 = i5; c.be = be;
    plan.push_back(c);
  endfunction

  // Reference: the full expected cycle sequence of one instruction, given the
  // number of wait cycles memory inserts before responding.
  function automatic void build_plan(string nm, lc3b_opcode op, logic i5, logic be,
                                     int unsigned w1, int unsigned w2);
    outv_t e;
    plan.delete();
    e = '0; e.marmux = 1; e.load_mar = 1; e.load_pc = 1;
    add({nm, ".fetch1"}, e, rj(), jop(), rj(), rj());
    for (int unsigned i = 0; i <= w1; i++) begin
      e = '0; e.mem_read = 1; e.mdrmux = 1; e.load_mdr = 1;
      add({nm, ".fetch2"}, e, logic'(i == w1), jop(), rj(), rj());
    end
    e = '0; e.load_ir = 1;
    add({nm, ".fetch3"}, e, rj(), op, i5, rj());
    e = '0;
    add({nm, ".decode"}, e, rj(), op, i5, rj());
    case (op)
      op_add, op_and: begin
        e = '0; e.aluop = (op == op_add) ? alu_add : alu_and;
        e.alumux = {1'b0, i5}; e.load_regfile = 1; e.load_cc = 1;
        add({nm, ".exec"}, e, rj(), op, i5, rj());
      end
      op_not: begin
        e = '0; e.aluop = alu_not; e.load_regfile = 1; e.load_cc = 1;
        add({nm, ".exec"}, e, rj(), op, i5, rj());
      end
      op_lea: begin
        e = '0; e.regfilemux = 2; e.load_regfile = 1; e.load_cc = 1;
        add({nm, ".exec"}, e, rj(), op, i5, rj());
      end
      op_jmp: begin
        e = '0; e.pcmux = 2; e.load_pc = 1;
        add({nm, ".exec"}, e, rj(), op, i5, rj());
      end
      op_br: begin
        e = '0;
        add({nm, ".br"}, e, rj(), op, i5, be);
        if (be) begin
          e.pcmux = 1; e.load_pc = 1;
          add({nm, ".taken"}, e, rj(), op, i5, rj());
        end
      end
      op_ldr, op_str: begin
        e = '0; e.alumux = 2; e.aluop = alu_add; e.load_mar = 1;
        add({nm, ".calc"}, e, rj(), op, i5, rj());
        if (op == op_ldr) begin
          for (int unsigned i = 0; i <= w2; i++) begin
            e = '0; e.mem_read = 1; e.mdrmux = 1; e.load_mdr = 1;
            add({nm, ".ldr1"}, e, logic'(i == w2), op, i5, rj());
          end
          e = '0; e.regfilemux = 1; e.load_regfile = 1; e.load_cc = 1;
          add({nm, ".ldr2"}, e, rj(), op, i5, rj());
        end else begin
          e = '0; e.storemux = 1; e.aluop = alu_pass; e.load_mdr = 1;
          add({nm, ".str1"}, e, rj(), op, i5, rj());
          for (int unsigned i = 0; i <= w2; i++) begin
            e = '0; e.mem_write = 1;
            add({nm, ".str2"}, e, logic'(i == w2), op, i5, rj());
          end
        end
      end
      default: ;
    endcase
  endfunction

  task automatic drive(cyc_t c);
    @(posedge clk);
    #1;
    reset = c.rst; mem_resp = c.resp; opcode = c.op;
    instruction5 = c.i5; branch_enable = c.be;
    sb.push_back(c);
  endtask

  task automatic reset_cycles(string nm, int unsigned n);
    cyc_t c;
    for (int unsigned i = 0; i < n; i++) begin
      c.tag = {nm, ".reset"}; c.exp = '0; c.rst = 1'b1; c.resp = rj();
      c.op = jop(); c.i5 = rj(); c.be = rj();
      drive(c);
    end
  endtask

  task automatic run_instr(string nm, lc3b_opcode op, logic i5, logic be,
                           int unsigned w1, int unsigned w2, int abort_at, int unsigned rst_len);
    cyc_t q[$];
    build_plan(nm, op, i5, be, w1, w2);
    q = plan;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        reset_cycles(nm, rst_len);
        return;
      end
      drive(q[i]);
    end
  endtask

  initial begin : monitor
    cyc_t  c;
    outv_t act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        c = sb.pop_front();
        act.load_pc = load_pc; act.load_ir = load_ir; act.load_regfile = load_regfile;
        act.load_mar = load_mar; act.load_mdr = load_mdr; act.load_cc = load_cc;
        act.pcmux = pcmux_sel; act.marmux = marmux_sel; act.mdrmux = mdrmux_sel;
        act.alumux = alumux_sel; act.regfilemux = regfilemux_sel;
        act.storemux = storemux_sel; act.aluop = aluop;
        act.mem_read = mem_read; act.mem_write = mem_write;
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %05h expected %05h", c.tag, act, c.exp);
        end
      end
    end
  end

  initial begin : stim
    int ab;
    reset_cycles("init", 2);
    run_instr("idle_add", op_add, 1'b0, 1'b0, 4, 0, -1, 0);
    run_instr("add_imm5", op_add, 1'b1, 1'b0, 0, 0, -1, 0);
    run_instr("and_reg", op_and, 1'b0, 1'b0, 1, 0, -1, 0);
    run_instr("not", op_not, 1'b1, 1'b0, 0, 0, -1, 0);
    run_instr("lea", op_lea, 1'b0, 1'b1, 0, 0, -1, 0);
    run_instr("jmp", op_jmp, 1'b0, 1'b0, 2, 0, -1, 0);
    run_instr("str_w3", op_str, 1'b0, 1'b0, 0, 2, -1, 0);
    run_instr("ldr", op_ldr, 1'b1, 1'b0, 0, 0, -1, 0);
    run_instr("ldr_w2", op_ldr, 1'b0, 1'b0, 1, 2, -1, 0);
    run_instr("br_nt", op_br, 1'b0, 1'b0, 0, 0, -1, 0);
    run_instr("br_t", op_br, 1'b0, 1'b1, 0, 0, -1, 0);
    run_instr("rst_fetch2", op_add, 1'b1, 1'b0, 2, 0, 2, 1);
    run_instr("trap", op_trap, 1'b1, 1'b1, 0, 0, -1, 0);
    run_instr("rst_ldr1", op_ldr, 1'b0, 1'b0, 0, 3, 6, 2);
    run_instr("rst_str2", op_str, 1'b0, 1'b0, 0, 3, 8, 1);
    for (int n = 0; n < 300; n++) begin
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr($sformatf("rnd%0d", n), jop(), rj(), rj(),
                $urandom_range(0, 3), $urandom_range(0, 3), ab, $urandom_range(1, 2));
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
